// File: rtl/mips_pkg.sv
// Shared pipeline types for the MIPS datapath hazard logic.
// Holds forwarding-select codes and the scoreboard entry struct.
package mips_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    typedef struct packed {
        logic [4:0] dst;
        logic       we;
        logic       load;
    } sb_entry_t;

    // Register $0 is never a real destination, so its write enable is
    // dropped at capture time.
    function automatic sb_entry_t sb_mk(
        input logic [4:0] dst,
        input logic       we,
        input logic       load
    );
        sb_entry_t e;
        e.dst  = dst;
        e.we   = we & (dst != 5'd0);
        e.load = load;
        return e;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forwarding priority selector (EX > MEM > WB > regfile).
// Ports: src/uses (ID operand), EX/MEM/WB scoreboard fields, sel out.
module fwd_sel
    import mips_pkg::*;
(
    input  logic [4:0] i_src,
    input  logic       i_uses,
    input  logic [4:0] i_ex_dst,
    input  logic       i_ex_we,
    input  logic       i_ex_load,
    input  logic [4:0] i_mem_dst,
    input  logic       i_mem_we,
    input  logic [4:0] i_wb_dst,
    input  logic       i_wb_we,
    output logic [1:0] o_sel
);

    always_comb begin
        o_sel = FWD_RF;
        if (i_uses) begin
            // A load in EX has no data yet; that case is a stall.
            if (i_ex_we && !i_ex_load && i_src == i_ex_dst)
                o_sel = FWD_EX;
            else if (i_mem_we && i_src == i_mem_dst)
                o_sel = FWD_MEM;
            else if (i_wb_we && i_src == i_wb_dst)
                o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ID-stage hazard controller: EX/MEM/WB scoreboard, load-use stall,
// hold freeze, forwarding selects and a saturating stall counter.
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_dst,
    input  logic             id_reg_write,
    input  logic             id_load,
    input  logic             hold,
    output logic             pc_le,
    output logic             npc_le,
    output logic             if_id_le,
    output logic             cu_mux_s,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt
);

    sb_entry_t        r_ex;
    sb_entry_t        r_mem;
    logic [4:0]       r_wb_dst;
    logic             r_wb_we;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_hit_rs;
    logic w_hit_rt;
    logic w_luh;
    logic w_stall;

    assign w_hit_rs = id_uses_rs && id_rs == r_ex.dst;
    assign w_hit_rt = id_uses_rt && id_rt == r_ex.dst;
    assign w_luh    = r_ex.we && r_ex.load
                      && (w_hit_rs || w_hit_rt);
    assign w_stall  = w_luh && !hold;

    assign pc_le     = !(w_luh || hold);
    assign npc_le    = pc_le;
    assign if_id_le  = pc_le;
    assign cu_mux_s  = w_stall;
    assign stall_cnt = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex        <= '0;
            r_mem       <= '0;
            r_wb_dst    <= '0;
            r_wb_we     <= 1'b0;
            r_stall_cnt <= '0;
        end else if (!hold) begin
            r_wb_dst <= r_mem.dst;
            r_wb_we  <= r_mem.we;
            r_mem    <= r_ex;
            // A stalled instruction stays in ID; EX gets a bubble.
            if (w_stall)
                r_ex <= '0;
            else
                r_ex <= sb_mk(id_dst, id_reg_write, id_load);
            if (w_stall && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    fwd_sel u_fwd_a (
        .i_src     (id_rs),
        .i_uses    (id_uses_rs),
        .i_ex_dst  (r_ex.dst),
        .i_ex_we   (r_ex.we),
        .i_ex_load (r_ex.load),
        .i_mem_dst (r_mem.dst),
        .i_mem_we  (r_mem.we),
        .i_wb_dst  (r_wb_dst),
        .i_wb_we   (r_wb_we),
        .o_sel     (fwd_a_sel)
    );

    fwd_sel u_fwd_b (
        .i_src     (id_rt),
        .i_uses    (id_uses_rt),
        .i_ex_dst  (r_ex.dst),
        .i_ex_we   (r_ex.we),
        .i_ex_load (r_ex.load),
        .i_mem_dst (r_mem.dst),
        .i_mem_we  (r_mem.we),
        .i_wb_dst  (r_wb_dst),
        .i_wb_we   (r_wb_we),
        .o_sel     (fwd_b_sel)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl: the driver queues the
// hand-derived outputs per cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic [4:0]  id_dst;
    logic        id_reg_write;
    logic        id_load;
    logic        hold;
    logic        pc_le;
    logic        npc_le;
    logic        if_id_le;
    logic        cu_mux_s;
    logic [1:0]  fwd_a_sel;
    logic [1:0]  fwd_b_sel;
    logic [15:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dst       (id_dst),
        .id_reg_write (id_reg_write),
        .id_load      (id_load),
        .hold         (hold),
        .pc_le        (pc_le),
        .npc_le       (npc_le),
        .if_id_le     (if_id_le),
        .cu_mux_s     (cu_mux_s),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        string       nm;
        logic        le;
        logic        cu;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string nm, input string f,
                       input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            cmp(e.nm, "pc_le",    int'(pc_le),     int'(e.le));
            cmp(e.nm, "npc_le",   int'(npc_le),    int'(e.le));
            cmp(e.nm, "if_id_le", int'(if_id_le),  int'(e.le));
            cmp(e.nm, "cu_mux_s", int'(cu_mux_s),  int'(e.cu));
            cmp(e.nm, "fwd_a",    int'(fwd_a_sel), int'(e.fa));
            cmp(e.nm, "fwd_b",    int'(fwd_b_sel), int'(e.fb));
            cmp(e.nm, "cnt",      int'(stall_cnt), int'(e.cnt));
        end
    end

    // One cycle: drive ID inputs after the edge, queue expected outputs.
    task automatic step(
        input string nm, input logic chk,
        input logic rst, input logic hd,
        input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt,
        input logic [4:0] dst, input logic rw, input logic ld,
        input logic le, input logic cu,
        input logic [1:0] fa, input logic [1:0] fb,
        input logic [15:0] cnt
    );
        exp_t e;
        @(posedge clk);
        #1;
        reset        = rst;
        hold         = hd;
        id_rs        = rs;
        id_rt        = rt;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_dst       = dst;
        id_reg_write = rw;
        id_load      = ld;
        if (chk) begin
            e.nm  = nm;
            e.le  = le;
            e.cu  = cu;
            e.fa  = fa;
            e.fb  = fb;
            e.cnt = cnt;
            q.push_back(e);
        end
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        id_rs = '0; id_rt = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_dst = '0; id_reg_write = 1'b0; id_load = 1'b0;

        step("rst0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("rst1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        // LBU r5 ; SUBU r6,r5,r7
        step("lbu",  1, 0, 0, 4, 0, 1, 0, 5, 1, 1, 1, 0, 0, 0, 0);
        step("luh",  1, 0, 0, 5, 7, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0);
        step("luh2", 1, 0, 0, 5, 7, 1, 1, 6, 1, 0, 1, 0, 2, 0, 1);

        // ADDIU r3 ; SUBU r4,r3,r3
        step("addiu", 1, 0, 0, 0, 0, 1, 0, 3, 1, 0, 1, 0, 0, 0, 1);
        step("b2b",   1, 0, 0, 3, 3, 1, 1, 4, 1, 0, 1, 0, 1, 1, 1);

        // three producers of r2, then consumers
        step("p2a",  1, 0, 0, 1, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 1);
        step("p2b",  1, 0, 0, 1, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 1);
        step("p2c",  1, 0, 0, 1, 1, 1, 1, 2, 1, 0, 1, 0, 0, 0, 1);
        step("allr2", 1, 0, 0, 2, 9, 1, 0, 10, 1, 0, 1, 0, 1, 0, 1);
        step("nop",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        step("wbr2", 1, 0, 0, 2, 10, 1, 1, 11, 1, 0, 1, 0, 3, 2, 1);

        // load to r0 then consumer of r0
        step("lwr0", 1, 0, 0, 1, 0, 1, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        step("r0use", 1, 0, 0, 0, 0, 1, 1, 12, 1, 0, 1, 0, 0, 0, 1);

        // hold for 3 cycles over a load-use
        step("lwr8", 1, 0, 0, 1, 0, 1, 0, 8, 1, 1, 1, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step("hold", 1, 0, 1, 8, 0, 1, 0, 13, 1, 0, 0, 0, 0, 0, 1);
        step("hstl", 1, 0, 0, 8, 0, 1, 0, 13, 1, 0, 0, 1, 0, 0, 1);
        step("hfwd", 1, 0, 0, 8, 0, 1, 0, 13, 1, 0, 1, 0, 2, 0, 2);

        // reset while stalled
        step("lwr9", 1, 0, 0, 1, 0, 1, 0, 9, 1, 1, 1, 0, 0, 0, 2);
        step("rstl", 1, 1, 0, 9, 0, 1, 0, 14, 1, 0, 0, 1, 0, 0, 2);
        step("prst", 1, 0, 0, 9, 0, 1, 0, 14, 1, 0, 1, 0, 0, 0, 0);

        // counter saturation
        step("lws",  1, 0, 0, 1, 0, 1, 0, 9, 1, 1, 1, 0, 0, 0, 0);
        step("sat0", 1, 0, 0, 9, 0, 1, 0, 15, 1, 0, 0, 1, 0, 0, 16'hFFFF);
        force dut.r_stall_cnt = 16'hFFFF;
        #2;
        release dut.r_stall_cnt;
        step("sat1", 1, 0, 0, 9, 0, 1, 0, 15, 1, 0, 1, 0, 2, 0, 16'hFFFF);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS datapath. It keeps a three-entry scoreboard of in-flight destination registers (EX, MEM, WB) and compares it against the source operands of the instruction in ID. From that comparison it drives three outputs:
- the load enables of the PC, nPC and IF/ID registers;
- the select `S` of ControlUnitMUX, which inserts a NOP bubble into ID/EX;
- the EX-stage operand forwarding selects.

It sits beside ControlUnit in the ID stage and replaces the constant-1 load enables currently tied into the PC and NPC registers.

## Interface
Parameters:
- `CNT_W`, default 16: width of the stall-cycle counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_rs`  in  5  rs field of the instruction in ID.
- `id_rt`  in  5  rt field of the instruction in ID.
- `id_uses_rs`  in  1  the ID instruction reads rs.
- `id_uses_rt`  in  1  the ID instruction reads rt.
- `id_dst`  in  5  final destination register of the ID instruction, after the WriteDestination mux (rd, rt or r31).
- `id_reg_write`  in  1  the ID instruction writes the register file.
- `id_load`  in  1  the ID instruction is a load (LBU, LW, …).
- `hold`  in  1  external freeze, e.g. data-memory wait.
- `pc_le`  out  1  load enable for the PC register.
- `npc_le`  out  1  load enable for the nPC register.
- `if_id_le`  out  1  load enable for the IF/ID register.
- `cu_mux_s`  out  1  ControlUnitMUX select; 1 forces all-zero (NOP) control signals into ID/EX.
- `fwd_a_sel`  out  2  forwarding select for operand A (rs).
- `fwd_b_sel`  out  2  forwarding select for operand B (rt).
- `stall_cnt`  out  CNT_W  saturating count of load-use stall cycles.

## Operation
- Scoreboard holds three entries: EX {dst, we, load}, MEM {dst, we, load} and WB {dst, we}.
- Each entry treats `we` as 0 whenever `dst == 0`. Register $0 never creates a hazard or a forward.
- Load-use hazard: `luh = EX.we & EX.load & ((id_uses_rs & id_rs == EX.dst) | (id_uses_rt & id_rt == EX.dst))`.
- `stall = luh & ~hold`.
- Enable and NOP outputs:
  - `pc_le = npc_le = if_id_le = ~(luh | hold)`.
  - `cu_mux_s = stall`.
  - During `hold`, `cu_mux_s = 0` (freeze; no bubble).
- Scoreboard advance on a rising edge when `hold = 0`:
  - WB ← MEM.
  - MEM ← EX.
  - EX ← {id_dst, id_reg_write, id_load} if `stall = 0`; otherwise EX ← a bubble (we = 0, load = 0).
- When `hold = 1`, the scoreboard and `stall_cnt` are unchanged.
- Forwarding select per operand (shown for A; B is identical using `id_rt` / `id_uses_rt`). Encoding: 00 = register file, 01 = EX ALU result, 10 = MEM result, 11 = WB data.
  - 01 if `EX.we & ~EX.load & id_rs == EX.dst`;
  - else 10 if `MEM.we & id_rs == MEM.dst`; a load in MEM forwards the data-memory output;
  - else 11 if `WB.we & id_rs == WB.dst`;
  - else 00.
  - Priority is EX > MEM > WB; the youngest producer wins.
  - If `id_uses_rs = 0`, `fwd_a_sel = 00`.
- `stall_cnt` increments by 1 on every edge where `stall = 1` and saturates at all-ones.
- The forwarding selects are computed in ID and registered into ID/EX by the pipeline registers, not by this block.

## Timing
- The scoreboard and `stall_cnt` are the only state. All other outputs are combinational from that state plus the ID inputs, valid in the same cycle.
- Load-use case: the dependent instruction stalls exactly 1 cycle.
  - On the following cycle the load is in MEM, `luh = 0`, and the select is 10.
  - A second back-to-back dependent instruction needs no further stall.
- Reset (synchronous, active-high):
  - All scoreboard `we` and `load` bits clear to 0; `dst` fields clear to 0; `stall_cnt` clears to 0.
  - Consequently, during reset and in the first cycle after it: `pc_le = npc_le = if_id_le = 1`, `cu_mux_s = 0`, both forwarding selects = 00 (`hold` is expected low).
- Reset while a stall is active: the stall is dropped in the next cycle (scoreboard empty) and the ID instruction proceeds.
- `hold` together with `luh`: hold wins. There is no bubble and no count; the stall is re-evaluated when `hold` drops.

## Structure
- Shared package `mips_pkg` holds:
  - the `FWD_RF`, `FWD_EX`, `FWD_MEM`, `FWD_WB` 2-bit constants;
  - a `sb_entry_t` struct {dst[4:0], we, load}.
- One sub-module, `fwd_sel`: the combinational per-operand priority selector, instantiated twice (rs, rt).
- Scoreboard shift and stall logic live in `hazard_ctrl`.

## Test plan
- LBU r5 followed by SUBU r6,r5,r7 → one cycle with `pc_le = if_id_le = 0` and `cu_mux_s = 1`; next cycle `fwd_a_sel = 10`; `stall_cnt = 1`.
- ADDIU r3, then SUBU r4,r3,r3 (back-to-back) → no stall; `fwd_a_sel = fwd_b_sel = 01`.
- Producers of r2 in EX, MEM and WB simultaneously, consumer reads r2 → `fwd_a_sel = 01`. Repeat with the producer only in WB → `fwd_a_sel = 11`.
- Load to r0 followed by a consumer of r0 → no stall; selects = 00.
- `hold = 1` for 3 cycles during a load-use condition → all LEs 0, `cu_mux_s = 0`, scoreboard frozen. After release, exactly one stall cycle follows.
- `reset` asserted mid-stall → next cycle LEs = 1, selects = 00, `stall_cnt = 0`. Separately, force `stall_cnt` to 0xFFFF plus one more stall → the count stays at 0xFFFF.
